// File: rtl/sample_capture_pkg.sv
// Shared definitions for the sample_capture slice: default widths and FSM state encodings.
package sample_capture_pkg;

  localparam int SAMPLE_WIDTH_DEF     = 18;
  localparam int OUT_WIDTH_DEF        = 8;
  localparam int NUM_SAMPLES_LOG2_DEF = 8;
  localparam int DECIM_DEF            = 4;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/sample_capture_if.sv
// Sample-in / waveform-RAM-out bundle between music player, capture block and display RAM.
interface sample_capture_if
  import sample_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = SAMPLE_WIDTH_DEF,
  parameter int OUT_WIDTH        = OUT_WIDTH_DEF,
  parameter int NUM_SAMPLES_LOG2 = NUM_SAMPLES_LOG2_DEF
);

  logic                        new_sample_ready;
  logic [SAMPLE_WIDTH-1:0]     new_sample_in;
  logic                        wave_display_idle;
  logic [NUM_SAMPLES_LOG2:0]   write_address;
  logic                        write_enable;
  logic [OUT_WIDTH-1:0]        write_sample;
  logic                        read_index;

  // Source side: player/display environment driving the capture block
  modport master (
    output new_sample_ready,
    output new_sample_in,
    output wave_display_idle,
    input  write_address,
    input  write_enable,
    input  write_sample,
    input  read_index
  );

  // Capture block side
  modport slave (
    input  new_sample_ready,
    input  new_sample_in,
    input  wave_display_idle,
    output write_address,
    output write_enable,
    output write_sample,
    output read_index
  );

endinterface

// File: rtl/sample_capture_zero_cross_detector.sv
// Positive zero-crossing detector: remembers the sign of the last strobed sample and
// pulses pos_cross when a negative sample is followed by a non-negative one.
module zero_cross_detector (
  input  logic clk,
  input  logic reset,
  input  logic new_sample_ready,
  input  logic sample_sign,
  output logic pos_cross
);

  // Only the sign of the previous sample takes part in crossing detection.
  logic prev_sign_r;

  // Previous-sample sign register, updated on every strobe regardless of capture state
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sign_r <= 1'b0;
    end else if (new_sample_ready) begin
      prev_sign_r <= sample_sign;
    end else begin
      prev_sign_r <= prev_sign_r;
    end
  end

  assign pos_cross = new_sample_ready & prev_sign_r & ~sample_sign;

endmodule

// File: rtl/sample_capture.sv
// Captures one display window of samples into the idle bank of a dual-bank waveform RAM.
// Optional build macro CAPTURE_DECIMATE_EN: store every DECIM-th strobe after the trigger.
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = SAMPLE_WIDTH_DEF,
  parameter int OUT_WIDTH        = OUT_WIDTH_DEF,
  parameter int NUM_SAMPLES_LOG2 = NUM_SAMPLES_LOG2_DEF,
  parameter int DECIM            = DECIM_DEF
) (
  input  logic           clk,
  input  logic           reset,
  sample_capture_if.slave bus
);

  localparam int IDX_W = NUM_SAMPLES_LOG2;
  localparam logic [IDX_W-1:0] INDEX_LAST = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] INDEX_ZERO = {IDX_W{1'b0}};

  cap_state_e         state_r, state_s;
  logic [IDX_W-1:0]   index_r, index_s;
  logic               we_r, we_s;
  logic [IDX_W:0]     addr_r, addr_s;
  logic [OUT_WIDTH-1:0] wsamp_r, wsamp_s;
  logic               read_index_r, read_index_s;
  logic               pos_cross_s;
  logic               take_s;

  // Signed two's complement to offset binary, keeping the top OUT_WIDTH bits.
  function automatic logic [OUT_WIDTH-1:0] to_display(input logic [SAMPLE_WIDTH-1:0] s);
    return {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2 -: OUT_WIDTH-1]};
  endfunction

  zero_cross_detector u_zero_cross (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (bus.new_sample_ready),
    .sample_sign      (bus.new_sample_in[SAMPLE_WIDTH-1]),
    .pos_cross        (pos_cross_s)
  );

`ifdef CAPTURE_DECIMATE_EN
  localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);
  localparam logic [PHASE_W-1:0] PHASE_ZERO = {PHASE_W{1'b0}};

  logic [PHASE_W-1:0] phase_r, phase_s;

  // Stride phase: held at zero while armed so it restarts on every trigger
  always_comb begin
    phase_s = phase_r;
    take_s  = 1'b0;
    if (state_r == ST_ARMED) begin
      phase_s = PHASE_ZERO;
    end else if ((state_r == ST_ACTIVE) && bus.new_sample_ready) begin
      take_s  = (phase_r == PHASE_ZERO);
      phase_s = (phase_r == PHASE_LAST) ? PHASE_ZERO : (phase_r + PHASE_W'(1));
    end else begin
      phase_s = phase_r;
    end
  end

  // Stride phase register
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r <= PHASE_ZERO;
    end else begin
      phase_r <= phase_s;
    end
  end
`else
  // Without decimation every strobe is a write candidate; the stride is not used.
  logic unused_decim_s;
  assign unused_decim_s = (DECIM > 0);
  assign take_s         = bus.new_sample_ready;
`endif

  // Capture FSM next-state and next-output logic
  always_comb begin
    state_s      = state_r;
    index_s      = index_r;
    we_s         = 1'b0;
    addr_s       = addr_r;
    wsamp_s      = wsamp_r;
    read_index_s = read_index_r;
    case (state_r)
      ST_ARMED: begin
        // The trigger sample itself is not stored.
        if (pos_cross_s) begin
          state_s = ST_ACTIVE;
          index_s = INDEX_ZERO;
        end else begin
          state_s = ST_ARMED;
        end
      end
      ST_ACTIVE: begin
        if (take_s) begin
          we_s    = 1'b1;
          addr_s  = {~read_index_r, index_r};
          wsamp_s = to_display(bus.new_sample_in);
          if (index_r == INDEX_LAST) begin
            state_s = ST_WAIT;
          end else begin
            index_s = index_r + IDX_W'(1);
          end
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      ST_WAIT: begin
        // A strobe arriving in the swap cycle only updates the detector's history.
        if (bus.wave_display_idle) begin
          read_index_s = ~read_index_r;
          state_s      = ST_ARMED;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_ARMED;
      end
    endcase
  end

  // State, index and registered RAM-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_ARMED;
      index_r      <= INDEX_ZERO;
      we_r         <= 1'b0;
      addr_r       <= {(IDX_W+1){1'b0}};
      wsamp_r      <= {OUT_WIDTH{1'b0}};
      read_index_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      index_r      <= index_s;
      we_r         <= we_s;
      addr_r       <= addr_s;
      wsamp_r      <= wsamp_s;
      read_index_r <= read_index_s;
    end
  end

  assign bus.write_enable  = we_r;
  assign bus.write_address = addr_r;
  assign bus.write_sample  = wsamp_r;
  assign bus.read_index    = read_index_r;

endmodule

// File: tb/tb_sample_capture.sv
// Scoreboard bench for sample_capture: expected RAM writes are queued as stimulus is driven
// and checked as the DUT emits them; also covers reset, bank swap and no-trigger cases.
module tb_sample_capture;
  import sample_capture_pkg::*;

  localparam int SW = 18;
  localparam int OW = 8;
  localparam int NL = 8;
`ifdef CAPTURE_DECIMATE_EN
  localparam int STRIDE = 4;
`else
  localparam int STRIDE = 1;
`endif

  typedef struct packed {
    logic [NL:0]   addr;
    logic [OW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  wr_t  sb[$];
  wr_t  exp_w;
  int   vectors     = 0;
  int   miscompares = 0;
  int   write_count = 0;

  always #5 clk = ~clk;

  sample_capture_if #(.SAMPLE_WIDTH(SW), .OUT_WIDTH(OW), .NUM_SAMPLES_LOG2(NL)) bus ();

  sample_capture #(
    .SAMPLE_WIDTH(SW), .OUT_WIDTH(OW), .NUM_SAMPLES_LOG2(NL), .DECIM(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [OW-1:0] exp_disp(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s ^ 18'h20000;
    return t[SW-1 -: OW];
  endfunction

  // Write monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      write_count++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                 bus.write_address, bus.write_sample);
      end else begin
        exp_w = sb.pop_front();
        if ({bus.write_address, bus.write_sample} !== {exp_w.addr, exp_w.data}) begin
          miscompares++;
          $display("FAIL write_data: got addr=%h data=%h, expected addr=%h data=%h",
                   bus.write_address, bus.write_sample, exp_w.addr, exp_w.data);
        end
      end
    end
  end

  task automatic send(input logic [SW-1:0] s);
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = s;
    @(posedge clk); #1;
    bus.new_sample_ready = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Crossing (-5 then +3) followed by nwrites*STRIDE back-to-back strobes
  task automatic capture(input logic bank, input int nwrites, input bit rand_data);
    logic [SW-1:0] s;
    wr_t e;
    send(18'h3FFFB);
    send(18'h00003);
    for (int i = 0; i < nwrites * STRIDE; i++) begin
      s = rand_data ? 18'($urandom) : 18'h1FFFF;
      if ((i % STRIDE) == 0) begin
        e.addr = {bank, 8'(i / STRIDE)};
        e.data = exp_disp(s);
        sb.push_back(e);
      end
      send(s);
    end
  endtask

  task automatic check_drained(input int exp_writes);
    idle_cycles(2);
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL missing_writes: got %0d pending, expected 0", sb.size());
    end
    vectors++;
    if (write_count !== exp_writes) begin
      miscompares++;
      $display("FAIL write_count: got %0d, expected %0d", write_count, exp_writes);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge clk);
    vectors++;
    if ({bus.write_enable, bus.write_address, bus.write_sample, bus.read_index} !== 19'h0) begin
      miscompares++;
      $display("FAIL %s: got we=%b addr=%h data=%h ri=%b, expected all 0", tag,
               bus.write_enable, bus.write_address, bus.write_sample, bus.read_index);
    end
  endtask

  task automatic check_read_index(input string tag, input logic exp_ri);
    @(negedge clk);
    vectors++;
    if (bus.read_index !== exp_ri) begin
      miscompares++;
      $display("FAIL %s: got read_index=%b, expected %b", tag, bus.read_index, exp_ri);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    send(18'h3FFFB);
    send(18'h00003);
    send(18'h1FFFF);
    check_outputs_zero("reset_outputs");
    @(posedge clk); #1;
    reset = 1'b0;
    check_outputs_zero("after_reset_outputs");
    @(posedge clk); #1;
  endtask

  task automatic test_capture_bank1();
    write_count = 0;
    capture(1'b1, 256, 1'b0);
    for (int i = 0; i < 20; i++) send(18'h1FFFF);
    check_drained(256);
    check_read_index("wait_no_swap", 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_bank_swap();
    write_count = 0;
    send(18'h3FFFB);
    bus.wave_display_idle = 1'b1;
    send(18'h00003);
    bus.wave_display_idle = 1'b0;
    check_read_index("swap_to_1", 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send(18'h00003);
    check_drained(0);
    capture(1'b0, 256, 1'b1);
    for (int i = 0; i < 5; i++) send(18'h00000);
    check_drained(256);
    check_read_index("bank0_capture_ri", 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic test_no_trigger();
    write_count = 0;
    bus.wave_display_idle = 1'b1;
    @(posedge clk); #1;
    check_read_index("swap_to_0", 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) send(18'd100);
    check_drained(0);
    check_read_index("idle_ignored_armed", 1'b0);
    @(posedge clk); #1;
    bus.wave_display_idle = 1'b0;
  endtask

  task automatic test_reset_mid_capture();
    write_count = 0;
    capture(1'b1, 100, 1'b1);
    reset = 1'b1;
    send(18'h1FFFF);
    reset = 1'b0;
    check_outputs_zero("mid_capture_reset");
    @(posedge clk); #1;
    send(18'h00003);
    for (int i = 0; i < 50; i++) send(18'd50);
    check_drained(100);
    capture(1'b1, 16, 1'b1);
    check_drained(116);
  endtask

  initial begin
    reset                 = 1'b1;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = 18'h0;
    bus.wave_display_idle = 1'b0;
    test_reset();
    test_capture_bank1();
    test_bank_swap();
    test_no_trigger();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
